// File: rtl/serial_word_loader.sv
// serial_word_loader
// Collects a bit-serial frame, MSB first, into an N-bit word. When PARITY_EN
// is set, one even-parity bit follows the data. A good frame is handed to the
// downstream load/clear register with a one-cycle reg_load strobe. An abort
// asks that register to zero itself with a one-cycle reg_clear strobe.
// Every output comes straight from a flop.

module serial_word_loader #(
    parameter int N         = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         bit_valid,
    input  logic         bit_in,
    input  logic         abort,
    output logic [N-1:0] reg_data,
    output logic         reg_load,
    output logic         reg_clear,
    output logic         busy,
    output logic         frame_err
);

    // The counter has to be able to hold N.
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_LOAD   = 2'd3;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [N-1:0]  WORD_ZERO = {N{1'b0}};

    // Even-parity check over a word plus its parity bit. A result of 1 means
    // the parity is bad.
    function automatic logic parity_bad(input logic [N-1:0] word, input logic pbit);
        return (^word) ^ pbit;
    endfunction

    logic [1:0]    state_r;
    logic [N-1:0]  sh_r;
    logic [CW-1:0] cnt_r;
    logic [N-1:0]  data_r;
    logic          load_r;
    logic          clear_r;
    logic          busy_r;
    logic          err_r;

    logic [1:0]    state_nx_s;
    logic [N-1:0]  sh_nx_s;
    logic [CW-1:0] cnt_nx_s;
    logic [N-1:0]  data_nx_s;
    logic          load_nx_s;
    logic          clear_nx_s;
    logic          err_nx_s;
    logic [N-1:0]  shifted_s;

    assign shifted_s = {sh_r[N-2:0], bit_in};

    // Next-state logic. Abort overrides all other inputs. The strobes are
    // decided here so that they appear in the cycle after the deciding edge.
    always_comb begin
        state_nx_s = state_r;
        sh_nx_s    = sh_r;
        cnt_nx_s   = cnt_r;
        data_nx_s  = data_r;
        load_nx_s  = 1'b0;
        clear_nx_s = 1'b0;
        err_nx_s   = err_r;

        if (abort) begin
            // The frame is dropped. reg_data and frame_err keep their values.
            state_nx_s = ST_IDLE;
            clear_nx_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nx_s = ST_SHIFT;
                        sh_nx_s    = WORD_ZERO;
                        cnt_nx_s   = CNT_ZERO;
                        err_nx_s   = 1'b0;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (bit_valid) begin
                        sh_nx_s  = shifted_s;
                        cnt_nx_s = cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            if (PARITY_EN) begin
                                state_nx_s = ST_PARITY;
                            end else begin
                                // With no parity bit, the word that is just
                                // complete goes straight to the output.
                                state_nx_s = ST_LOAD;
                                data_nx_s  = shifted_s;
                                load_nx_s  = 1'b1;
                            end
                        end else begin
                            state_nx_s = ST_SHIFT;
                        end
                    end else begin
                        // Stall. There is no timeout.
                        state_nx_s = ST_SHIFT;
                    end
                end
                ST_PARITY: begin
                    if (bit_valid) begin
                        if (parity_bad(sh_r, bit_in)) begin
                            state_nx_s = ST_IDLE;
                            err_nx_s   = 1'b1;
                        end else begin
                            state_nx_s = ST_LOAD;
                            data_nx_s  = sh_r;
                            load_nx_s  = 1'b1;
                        end
                    end else begin
                        state_nx_s = ST_PARITY;
                    end
                end
                ST_LOAD: begin
                    // reg_load is high for this one cycle.
                    state_nx_s = ST_IDLE;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers, with a synchronous reset. A reset in the
    // middle of a frame gives no strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            sh_r    <= WORD_ZERO;
            cnt_r   <= CNT_ZERO;
            data_r  <= WORD_ZERO;
            load_r  <= 1'b0;
            clear_r <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            sh_r    <= sh_nx_s;
            cnt_r   <= cnt_nx_s;
            data_r  <= data_nx_s;
            load_r  <= load_nx_s;
            clear_r <= clear_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            err_r   <= err_nx_s;
        end
    end

    assign reg_data  = data_r;
    assign reg_load  = load_r;
    assign reg_clear = clear_r;
    assign busy      = busy_r;
    assign frame_err = err_r;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader. It uses an 8-bit instance with parity
// and a 4-bit instance without parity.

module tb_serial_word_loader;

    logic       clk = 1'b0;
    logic       rst, start, bv, bi, ab;
    logic [7:0] reg_data;
    logic       reg_load, reg_clear, busy, frame_err;

    logic       rst4, start4, bv4, bi4, ab4;
    logic [3:0] reg_data4;
    logic       reg_load4, reg_clear4, busy4, frame_err4;

    int pass_cnt  = 0;
    int total_cnt = 0;

    serial_word_loader #(.N(8), .PARITY_EN(1'b1)) dut8 (
        .clk(clk), .reset(rst), .start(start), .bit_valid(bv), .bit_in(bi),
        .abort(ab), .reg_data(reg_data), .reg_load(reg_load),
        .reg_clear(reg_clear), .busy(busy), .frame_err(frame_err)
    );

    serial_word_loader #(.N(4), .PARITY_EN(1'b0)) dut4 (
        .clk(clk), .reset(rst4), .start(start4), .bit_valid(bv4), .bit_in(bi4),
        .abort(ab4), .reg_data(reg_data4), .reg_load(reg_load4),
        .reg_clear(reg_clear4), .busy(busy4), .frame_err(frame_err4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Sends the first nbits of w, MSB first, on dut8. After every valid bit
    // it inserts gap idle cycles. No load may occur while bits are shifting.
    task automatic shift_bits(input logic [7:0] w, input int nbits, input int gap);
        for (int i = 0; i < nbits; i++) begin
            bv = 1'b1;
            bi = w[7-i];
            tick();
            check("shift_noload", 32'(reg_load), 32'd0);
            check("shift_busy", 32'(busy), 32'd1);
            bv = 1'b0;
            for (int g = 0; g < gap; g++) begin
                tick();
                check("gap_noload", 32'(reg_load), 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bv = 1'b0; bi = 1'b0; ab = 1'b0;
        rst4 = 1'b1; start4 = 1'b0; bv4 = 1'b0; bi4 = 1'b0; ab4 = 1'b0;
        tick();
        tick();
        check("rst_data", 32'(reg_data), 32'h00);
        check("rst_load", 32'(reg_load), 32'd0);
        check("rst_clear", 32'(reg_clear), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst4_data", 32'(reg_data4), 32'h0);
        rst = 1'b0;
        rst4 = 1'b0;

        // T1: A5 with correct parity 0
        start = 1'b1;
        tick();
        check("t1_busy", 32'(busy), 32'd1);
        start = 1'b0;
        shift_bits(8'hA5, 8, 0);
        bv = 1'b1; bi = 1'b0;
        tick();
        bv = 1'b0;
        check("t1_load", 32'(reg_load), 32'd1);
        check("t1_data", 32'(reg_data), 32'hA5);
        check("t1_err", 32'(frame_err), 32'd0);
        check("t1_clear", 32'(reg_clear), 32'd0);
        tick();
        check("t1_load_done", 32'(reg_load), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_data_hold", 32'(reg_data), 32'hA5);

        // T2: A5 with bad parity 1
        start = 1'b1;
        tick();
        start = 1'b0;
        shift_bits(8'hA5, 8, 0);
        bv = 1'b1; bi = 1'b1;
        tick();
        bv = 1'b0;
        check("t2_noload", 32'(reg_load), 32'd0);
        check("t2_err", 32'(frame_err), 32'd1);
        check("t2_idle", 32'(busy), 32'd0);
        check("t2_data_hold", 32'(reg_data), 32'hA5);
        tick();
        check("t2_err_sticky", 32'(frame_err), 32'd1);
        check("t2_noload2", 32'(reg_load), 32'd0);

        // T3: 3C with three idle cycles after every valid bit. The start also clears frame_err.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_err_cleared", 32'(frame_err), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        shift_bits(8'h3C, 8, 3);
        check("t3_data_old", 32'(reg_data), 32'hA5);
        bv = 1'b1; bi = 1'b0;
        tick();
        bv = 1'b0;
        check("t3_load", 32'(reg_load), 32'd1);
        check("t3_data", 32'(reg_data), 32'h3C);
        tick();
        check("t3_load_done", 32'(reg_load), 32'd0);

        // T4: abort after 4 bits, then load FF
        start = 1'b1;
        tick();
        start = 1'b0;
        shift_bits(8'hB0, 4, 0);
        ab = 1'b1;
        tick();
        ab = 1'b0;
        check("t4_clear", 32'(reg_clear), 32'd1);
        check("t4_noload", 32'(reg_load), 32'd0);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_data_hold", 32'(reg_data), 32'h3C);
        tick();
        check("t4_clear_done", 32'(reg_clear), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        shift_bits(8'hFF, 8, 0);
        bv = 1'b1; bi = 1'b0;
        tick();
        bv = 1'b0;
        check("t4_load", 32'(reg_load), 32'd1);
        check("t4_data", 32'(reg_data), 32'hFF);
        tick();

        // Abort arrives together with the parity bit: abort wins.
        start = 1'b1;
        tick();
        start = 1'b0;
        shift_bits(8'h12, 8, 0);
        bv = 1'b1; bi = 1'b0; ab = 1'b1;
        tick();
        bv = 1'b0; ab = 1'b0;
        check("abl_clear", 32'(reg_clear), 32'd1);
        check("abl_noload", 32'(reg_load), 32'd0);
        check("abl_data", 32'(reg_data), 32'hFF);
        tick();
        check("abl_clear_done", 32'(reg_clear), 32'd0);

        // Start together with abort: abort wins and the block stays idle.
        start = 1'b1; ab = 1'b1;
        tick();
        start = 1'b0; ab = 1'b0;
        check("sa_idle", 32'(busy), 32'd0);
        check("sa_clear", 32'(reg_clear), 32'd1);
        tick();
        check("sa_clear_done", 32'(reg_clear), 32'd0);

        // T5: reset after 5 bits
        start = 1'b1;
        tick();
        start = 1'b0;
        shift_bits(8'hF8, 5, 0);
        rst = 1'b1;
        tick();
        check("t5_data", 32'(reg_data), 32'h00);
        check("t5_load", 32'(reg_load), 32'd0);
        check("t5_clear", 32'(reg_clear), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        tick();
        check("t5_post_load", 32'(reg_load), 32'd0);
        check("t5_post_clear", 32'(reg_clear), 32'd0);

        // T6: 4-bit instance without parity, bits 1,1,0,1, with start pulsed mid-frame
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("t6_busy", 32'(busy4), 32'd1);
        bv4 = 1'b1; bi4 = 1'b1;
        tick();
        check("t6_b1_noload", 32'(reg_load4), 32'd0);
        bi4 = 1'b1; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("t6_b2_noload", 32'(reg_load4), 32'd0);
        bi4 = 1'b0;
        tick();
        check("t6_b3_noload", 32'(reg_load4), 32'd0);
        bi4 = 1'b1;
        tick();
        bv4 = 1'b0;
        check("t6_load", 32'(reg_load4), 32'd1);
        check("t6_data", 32'(reg_data4), 32'hD);
        check("t6_err", 32'(frame_err4), 32'd0);
        tick();
        check("t6_load_done", 32'(reg_load4), 32'd0);
        check("t6_idle", 32'(busy4), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
